// File: rtl/data_bus_resp_pkg.sv
// Shared constants for the data-bus responder: region decode, MMIO register
// map, reset values, interrupt bit assignment and a byte-lane merge helper.
package data_bus_resp_pkg;

   // Address field that selects the MMIO region
   localparam int unsigned REGION_MSB = 31;
   localparam int unsigned REGION_LSB = 28;

   // MMIO register map, decoded on addr[3:2]
   typedef enum logic [1:0] {
      MMIO_MTIME    = 2'd0,
      MMIO_MTIMECMP = 2'd1,
      MMIO_IE       = 2'd2,
      MMIO_PEND     = 2'd3
   } mmio_reg_e;

   localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

   // Interrupt vector layout: bit 0 timer, bits 5:1 external lines 4:0
   localparam int unsigned IRQ_W       = 6;
   localparam int unsigned IRQ_TIMER   = 0;
   localparam int unsigned IRQ_EXT_LSB = 1;
   localparam int unsigned EXT_W       = 5;

   // Replace the byte lanes of old_w selected by sel with those of new_w
   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
      logic [31:0] merged;
      merged = old_w;
      for (int unsigned b = 0; b < 4; b++) begin
         if (sel[b]) merged[8*b +: 8] = new_w[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_bus_resp_irq_sync.sv
// irq_sync_edge: two-flop synchronizer plus delay flop per line; emits a
// one-cycle pulse on each synchronized rising edge.
module irq_sync_edge #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] sync1;
   logic [W-1:0] sync2;
   logic [W-1:0] dly;

   // Synchronizer chain and edge-detect delay stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         dly   <= '0;
      end else begin
         sync1 <= d_i;
         sync2 <= sync1;
         dly   <= sync2;
      end
   end

   assign rise_o = sync2 & ~dly;

endmodule

// File: rtl/data_bus_resp.sv
// data_bus_resp: data-memory bus responder (word RAM + MMIO timer/IRQ block)
// and source of the CPU's 6-bit interrupt vector.
// Optional feature: define DATA_BUS_RESP_TIMER_EN to build MTIME/MTIMECMP and
// the timer interrupt; otherwise offsets 0x0/0x4 read 0 and PEND[0] is 0.
module data_bus_resp
   import data_bus_resp_pkg::*;
#(
   parameter int unsigned RAM_AW      = 12,
   parameter logic [3:0]  MMIO_REGION = 4'h1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [3:0]        sel_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   input  logic [EXT_W-1:0]  ext_irq_i,
   output logic [IRQ_W-1:0]  int_o
);

   logic [31:0]       mem [2**RAM_AW];
   logic              is_mmio;
   mmio_reg_e         reg_sel;
   logic [RAM_AW-1:0] word_idx;
   logic              ram_wr;
   logic              mmio_wr;
   logic              timer_hit;
   logic [EXT_W-1:0]  ext_rise;
   logic [IRQ_W-1:0]  ie;
   logic [IRQ_W-1:0]  pend;
   logic [IRQ_W-1:0]  pend_clr;
   logic [IRQ_W-1:0]  pend_next;
   logic              unused_addr;

   assign is_mmio  = (addr_i[REGION_MSB:REGION_LSB] == MMIO_REGION);
   assign reg_sel  = mmio_reg_e'(addr_i[3:2]);
   assign word_idx = addr_i[RAM_AW+1:2];
   assign ram_wr   = ce_i & we_i & ~is_mmio;
   assign mmio_wr  = ce_i & we_i & is_mmio;

   // Byte offset and the aliased upper address bits are intentionally ignored
   assign unused_addr = ^{addr_i[1:0], addr_i[27:RAM_AW+2]};

`ifdef DATA_BUS_RESP_TIMER_EN
   logic [31:0] mtime;
   logic [31:0] mtimecmp;

   // Free-running timer and byte-lane writable compare register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime    <= '0;
         mtimecmp <= MTIMECMP_RST;
      end else begin
         mtime <= mtime + 32'd1;
         if (mmio_wr && reg_sel == MMIO_MTIMECMP)
            mtimecmp <= lane_merge(mtimecmp, wdata_i, sel_i);
      end
   end

   assign timer_hit = (mtime == mtimecmp);
`else
   assign timer_hit = 1'b0;
`endif

   irq_sync_edge #(.W(EXT_W)) u_irq_sync (
      .clk    (clk),
      .rst_n  (rst),
      .d_i    (ext_irq_i),
      .rise_o (ext_rise)
   );

   // Pending update: write-1-clear first, then sets, so a same-cycle set wins
   always_comb begin
      pend_clr = '0;
      if (mmio_wr && reg_sel == MMIO_PEND && sel_i[0])
         pend_clr = wdata_i[IRQ_W-1:0];
      pend_next = (pend & ~pend_clr) | {ext_rise, timer_hit};
   end

   // Interrupt enable, pending and registered interrupt vector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ie    <= '0;
         pend  <= '0;
         int_o <= '0;
      end else begin
         if (mmio_wr && reg_sel == MMIO_IE && sel_i[0])
            ie <= wdata_i[IRQ_W-1:0];
         pend  <= pend_next;
         int_o <= pend & ie;
      end
   end

   // RAM write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (ram_wr)
         mem[word_idx] <= lane_merge(mem[word_idx], wdata_i, sel_i);
   end

   // Zero-latency read mux; zero when idle or writing
   always_comb begin
      rdata_o = '0;
      if (ce_i && !we_i) begin
         if (is_mmio) begin
            case (reg_sel)
`ifdef DATA_BUS_RESP_TIMER_EN
               MMIO_MTIME:    rdata_o = mtime;
               MMIO_MTIMECMP: rdata_o = mtimecmp;
`endif
               MMIO_IE:       rdata_o = {{(32-IRQ_W){1'b0}}, ie};
               MMIO_PEND:     rdata_o = {{(32-IRQ_W){1'b0}}, pend};
               default:       rdata_o = '0;
            endcase
         end else begin
            rdata_o = mem[word_idx];
         end
      end
   end

endmodule

// File: tb/tb_data_bus_resp.sv
// Self-checking bench for data_bus_resp: table-driven bus vectors followed by
// hand-written interrupt, timer, collision and reset sequences.
module tb_data_bus_resp;

   localparam logic [31:0] A_MTIME    = 32'h1000_0000;
   localparam logic [31:0] A_MTIMECMP = 32'h1000_0004;
   localparam logic [31:0] A_IE       = 32'h1000_0008;
   localparam logic [31:0] A_PEND     = 32'h1000_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce_i = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [3:0]  sel_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic [4:0]  ext_irq_i = '0;
   logic [5:0]  int_o;

   int n_pass = 0;
   int n_chk  = 0;

   data_bus_resp dut (
      .clk       (clk),
      .rst       (rst),
      .ce_i      (ce_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .sel_i     (sel_i),
      .wdata_i   (wdata_i),
      .rdata_o   (rdata_o),
      .ext_irq_i (ext_irq_i),
      .int_o     (int_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // All tasks start and end just after a falling edge
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      ce_i = 1'b1; we_i = 1'b0; addr_i = a;
      #1 d = rdata_o;
      ce_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      ce_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; sel_i = s;
      @(negedge clk);
      ce_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic do_reset();
      ce_i = 1'b0; we_i = 1'b0; ext_irq_i = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;

      vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hAABB_CCDD, 32'h0};
      vecs[1]  = '{1'b1, 1'b1, 32'h0000_0010, 4'h5, 32'h1122_3344, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hAA22_CC44};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_4010, 4'h0, 32'h0,         32'hAA22_CC44};
      vecs[4]  = '{1'b1, 1'b0, 32'h2000_0010, 4'h0, 32'h0,         32'hAA22_CC44};
      vecs[5]  = '{1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h0};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h0,         32'h0};
      vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 4'hA, 32'hDEAD_BEEF, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'hDE00_BE00};
      vecs[9]  = '{1'b1, 1'b1, A_IE,          4'h1, 32'hFFFF_FFFF, 32'h0};
      vecs[10] = '{1'b1, 1'b1, A_IE,          4'hE, 32'h0,         32'h0};
      vecs[11] = '{1'b1, 1'b0, 32'h1ABC_DEF8, 4'h0, 32'h0,         32'h0000_003F};
      vecs[12] = '{1'b1, 1'b0, 32'hF000_0020, 4'h0, 32'h0,         32'hDE00_BE00};

      // Reset state while reset is held
      @(negedge clk);
      check("reset_int", {26'd0, int_o}, 32'h0);
      rd(A_IE, d);   check("reset_ie", d, 32'h0);
      rd(A_PEND, d); check("reset_pend", d, 32'h0);
      rst = 1'b1;
      cyc();

      // Table-driven bus accesses
      for (int i = 0; i < 13; i++) begin
         ce_i = vecs[i].ce; we_i = vecs[i].we; addr_i = vecs[i].addr;
         sel_i = vecs[i].sel; wdata_i = vecs[i].wdata;
         #1 check($sformatf("vec[%0d]", i), rdata_o, vecs[i].exp);
         @(negedge clk);
      end
      ce_i = 1'b0; we_i = 1'b0;

`ifdef DATA_BUS_RESP_TIMER_EN
      // MTIMECMP byte lanes and MTIME read-only
      do_reset();
      wr(A_MTIMECMP, 32'h1234_5678, 4'h3);
      wr(A_MTIME, 32'h0000_DEAD, 4'hF);
      rd(A_MTIMECMP, d); check("cmp_lanes", d, 32'hFFFF_5678);
      rd(A_MTIME, d);    check("mtime_ro", d, 32'd2);

      // Timer interrupt path
      do_reset();
      rd(A_MTIME, d); check("mtime_after_rst", d, 32'd0);
      wr(A_MTIMECMP, 32'd20, 4'hF);
      wr(A_IE, 32'h1, 4'h1);
      repeat (18) cyc();
      rd(A_MTIME, d);  check("mtime_20", d, 32'd20);
      rd(A_PEND, d);   check("tpend_before", d, 32'h0);
      cyc();
      rd(A_PEND, d);   check("tpend_set", d, 32'h1);
      check("tint_lag", {26'd0, int_o}, 32'h0);
      cyc();
      check("tint_set", {26'd0, int_o}, 32'h1);
      wr(A_PEND, 32'h1, 4'h1);
      check("tint_hold", {26'd0, int_o}, 32'h1);
      rd(A_PEND, d);   check("tpend_clr", d, 32'h0);
      cyc();
      check("tint_clr", {26'd0, int_o}, 32'h0);

      // Set wins over same-cycle write-1-clear
      do_reset();
      wr(A_MTIMECMP, 32'd10, 4'hF);
      repeat (9) cyc();
      rd(A_MTIME, d); check("coll_mtime", d, 32'd10);
      wr(A_PEND, 32'h1, 4'h1);
      rd(A_PEND, d);  check("coll_pend", d, 32'h1);
`else
      // Timer offsets absent
      do_reset();
      rd(A_MTIME, d);    check("nt_mtime", d, 32'h0);
      rd(A_MTIMECMP, d); check("nt_cmp", d, 32'h0);
      wr(A_MTIME, 32'hFFFF_FFFF, 4'hF);
      wr(A_MTIMECMP, 32'hFFFF_FFFF, 4'hF);
      rd(A_MTIME, d);    check("nt_mtime_wr", d, 32'h0);
      rd(A_MTIMECMP, d); check("nt_cmp_wr", d, 32'h0);
      wr(A_IE, 32'h3F, 4'h1);
      repeat (5) cyc();
      check("nt_int0", {31'd0, int_o[0]}, 32'h0);
      rd(A_PEND, d);     check("nt_pend", d, 32'h0);
`endif

      // External interrupt path on line 2
      do_reset();
      wr(A_IE, 32'h08, 4'h1);
      ext_irq_i = 5'b00100;
      cyc();
      check("ext_k", {26'd0, int_o}, 32'h0);
      cyc();
      rd(A_PEND, d); check("ext_k1_pend", d, 32'h0);
      cyc();
      rd(A_PEND, d); check("ext_k2_pend", d, 32'h08);
      check("ext_k2_int", {26'd0, int_o}, 32'h0);
      cyc();
      check("ext_k3_int", {26'd0, int_o}, 32'h08);
      wr(A_PEND, 32'h08, 4'h1);
      repeat (4) cyc();
      rd(A_PEND, d); check("ext_no_reset", d, 32'h0);
      check("ext_int_clr", {26'd0, int_o}, 32'h0);
      ext_irq_i = 5'b0;
      repeat (3) cyc();
      ext_irq_i = 5'b00100;
      repeat (2) cyc();
      rd(A_PEND, d); check("ext_re_before", d, 32'h0);
      cyc();
      rd(A_PEND, d); check("ext_re_set", d, 32'h08);

      // Asynchronous reset in the middle of activity
      do_reset();
`ifdef DATA_BUS_RESP_TIMER_EN
      wr(A_MTIMECMP, 32'd500, 4'hF);
      wr(A_IE, 32'h3F, 4'h1);
      ext_irq_i = 5'h1F;
      repeat (998) cyc();
      rd(A_MTIME, d); check("mid_mtime", d, 32'd1000);
      check("mid_int", {26'd0, int_o}, 32'h3F);
`else
      wr(A_IE, 32'h3F, 4'h1);
      ext_irq_i = 5'h1F;
      repeat (10) cyc();
      check("mid_int", {26'd0, int_o}, 32'h3E);
`endif
      #2 rst = 1'b0;
      #1 check("rst_int", {26'd0, int_o}, 32'h0);
      rd(A_PEND, d); check("rst_pend", d, 32'h0);
      rd(A_IE, d);   check("rst_ie", d, 32'h0);
`ifdef DATA_BUS_RESP_TIMER_EN
      rd(A_MTIMECMP, d); check("rst_cmp", d, 32'hFFFF_FFFF);
`endif
      ext_irq_i = 5'h0;
      @(negedge clk);
      rst = 1'b1;
`ifdef DATA_BUS_RESP_TIMER_EN
      rd(A_MTIME, d); check("rst_mtime0", d, 32'd0);
`endif
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
